grayscale_stream: RTL and testbench
===================================

# grayscale_stream

Parametrised, mode-selectable RGB-to-grayscale streaming block with integrated input and output FIFOs. It is the next-generation replacement for the fixed 8-bit grayscale top and sits between the pixel source and downstream filter stages. It adds:

- configurable channel width and FIFO depth;
- runtime selection between channel average and BT.601 luma;
- a frame pixel counter with an end-of-frame pulse;
- a credit-based pipeline that never drops or duplicates a pixel under backpressure.

## Interface
Parameters:
- WIDTH, 720: frame width in pixels.
- HEIGHT, 540: frame height in pixels.
- CH_W, 8: bits per colour channel and per output sample, range 4..16.
- FIFO_DEPTH, 32: entries in each FIFO; power of two, ≥4.

Ports:
- clock  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-low reset (asserts when 0).
- in_full  out  1  input FIFO full.
- in_wr_en  in  1  write strobe for the input FIFO.
- in_din  in  3*CH_W  pixel {R[3CH_W-1:2CH_W], G, B[CH_W-1:0]}.
- mode  in  1  0 = average, 1 = luma; sampled at frame start only.
- out_empty  out  1  output FIFO empty.
- out_rd_en  in  1  read strobe for the output FIFO.
- out_dout  out  CH_W  gray sample; valid whenever out_empty=0 (first-word fall-through).
- frame_done  out  1  one-cycle pulse at end of frame.

## Operation
- FIFOs:
  - Both FIFOs are show-ahead: dout holds the head entry while empty=0.
  - A write when full is ignored; a read when empty is ignored.
  - A write and a read in the same cycle on a non-full, non-empty FIFO are both performed.
- Issue rule:
  - The converter pops the input FIFO when in FIFO is non-empty AND (out FIFO occupancy + pixels in flight) < FIFO_DEPTH.
  - This credit check means a converted pixel always has room and the pipeline never stalls mid-flight.
- Pipeline: 2 stages after the pop.
  - S1 computes products and sums at full width.
  - S2 scales, truncates and writes the output FIFO.
- Arithmetic: R, G and B are unsigned.
  - mode 0: Y = floor((R+G+B)/3). This must be exact for all inputs, so any constant-multiply implementation must be proven exact over the full CH_W range.
  - mode 1: Y = (77·R + 150·G + 29·B) >> 8, floor.
  - Intermediate width is CH_W+9 bits. The result always fits in CH_W bits; no saturation is needed.
- Mode latch:
  - mode is captured into an internal register on the cycle the first pixel of a frame is popped (pixel count = 0).
  - Changes to mode mid-frame have no effect until the next frame.
- Frame counter:
  - Counts pixels written to the output FIFO, range 0..WIDTH·HEIGHT−1.
  - On the write of pixel WIDTH·HEIGHT−1, frame_done pulses for exactly one cycle and the counter wraps to 0.
  - The counter is free-running across frames. There are no idle states between frames.
- Reset (reset=0, asynchronous):
  - Both FIFOs are flushed.
  - Pipeline valid bits, the counter and the mode latch clear to 0.
  - Outputs during and after reset: in_full=0, out_empty=1, frame_done=0, out_dout=0.
  - Reset mid-frame discards all in-flight pixels; the next pixel is pixel 0 of a new frame.
  - Deassertion is used as-is; a synchronous release, if needed, is the integrator's responsibility.

## Timing
- in_full rises in the cycle after the write that fills the FIFO. It falls in the cycle after the first pop from a full FIFO.
- Minimum latency is 4 cycles from the in_wr_en edge to out_empty=0 with that pixel on out_dout:
  - write → in FIFO non-empty (1);
  - pop/S1 (1);
  - S2/out write (1);
  - out FIFO visible (1).
- Throughput is 1 pixel/cycle sustained when out_rd_en is held high and in_wr_en is held high.
- frame_done is asserted in the cycle after the clock edge that writes the last pixel into the output FIFO. That is the same cycle the pixel becomes visible if the FIFO was empty.
- Backpressure:
  - With out_rd_en=0, at most FIFO_DEPTH samples are accepted into the output FIFO. The input FIFO then fills and in_full=1.
  - No sample is lost or duplicated.

## Test plan
- Reset values: hold reset=0 mid-stream. Check in_full=0, out_empty=1 and frame_done=0 immediately (asynchronously). After release, check no stale data emerges.
- Average mode: mode=0, CH_W=8, write (10,20,31) then (255,255,255). Check out_dout reads 20 then 255; first sample visible 4 cycles after the write.
- Luma mode:
  - write (255,0,0) → 76;
  - write (0,255,0) → 149;
  - write (255,255,255) → 255.
  - Toggle mode mid-frame and check outputs stay luma until the counter wraps.
- Backpressure, FIFO_DEPTH=32, out_rd_en=0: write 80 pixels, honouring in_full. Check in_full=1 once 64 pixels are held (32 in each FIFO). Then drain and check all 64 accepted samples arrive in order, with none lost or duplicated.
- Frame boundary, WIDTH=4, HEIGHT=2: stream 16 pixels. Check frame_done pulses exactly twice, each time aligned to pixels 7 and 15. Check a mode change at pixel 3 takes effect at pixel 8.
- Random stress: random in_wr_en/out_rd_en over 10,000 random pixels in both modes. Compare output against a reference model. Check no write-when-full or read-when-empty corruption.

Source files
------------

// File: rtl/grayscale_stream.sv
// RGB-to-grayscale streaming block: show-ahead input/output FIFOs, a two-stage
// converter (channel average or BT.601 luma) and a free-running frame pixel counter.

module grayscale_stream_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [DW-1:0] din_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          wr_ok, rd_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign wr_ok   = wr_en_i && !full_o;
  assign rd_ok   = rd_en_i && !empty_o;
  // Head entry is presented combinationally; forced to zero while empty.
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + (AW+1)'(1);
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end
endmodule

module grayscale_stream #(
  parameter int unsigned WIDTH      = 720,
  parameter int unsigned HEIGHT     = 540,
  parameter int unsigned CH_W       = 8,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic              clock,
  input  logic              reset,
  output logic              in_full,
  input  logic              in_wr_en,
  input  logic [3*CH_W-1:0] in_din,
  input  logic              mode,
  output logic              out_empty,
  input  logic              out_rd_en,
  output logic [CH_W-1:0]   out_dout,
  output logic              frame_done
);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned SW      = CH_W + 9;
  localparam int unsigned NPIX    = WIDTH * HEIGHT;
  localparam int unsigned CW      = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CW-1:0] LAST_PIX = CW'(NPIX - 1);
  localparam logic [AW:0]   CREDITS  = FIFO_DEPTH[AW:0];
  // floor(x/3) == (x*349526)>>20 exactly for x < 2^19; 3*(2^16-1) stays below that.
  localparam int unsigned   DIV3_SH  = 20;
  localparam logic [18:0]   DIV3_K   = 19'd349526;

  logic [3*CH_W-1:0] in_dout;
  logic              in_empty;
  logic              pop;
  logic              out_rd_ok;
  logic              eff_mode;
  logic [CH_W-1:0]   px_r, px_g, px_b;
  logic [SW-1:0]     avg_sum, luma_sum;
  logic [CH_W-1:0]   avg_y, s2_y_d;

  logic              s1_v_q, s1_mode_q, s2_v_q;
  logic [SW-1:0]     s1_sum_q;
  logic [CH_W-1:0]   s2_y_q;
  logic [AW:0]       used_q, used_d;
  logic [CW-1:0]     issue_q, frame_q;
  logic              mode_q, frame_done_q;

  grayscale_stream_fifo #(
    .DW    (3*CH_W),
    .DEPTH (FIFO_DEPTH)
  ) u_in_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .wr_en_i (in_wr_en),
    .din_i   (in_din),
    .rd_en_i (pop),
    .dout_o  (in_dout),
    .full_o  (in_full),
    .empty_o (in_empty)
  );

  // Credits cover out FIFO occupancy plus pixels in flight, so S2 never finds it full.
  grayscale_stream_fifo #(
    .DW    (CH_W),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .wr_en_i (s2_v_q),
    .din_i   (s2_y_q),
    .rd_en_i (out_rd_en),
    .dout_o  (out_dout),
    .full_o  (),
    .empty_o (out_empty)
  );

  assign frame_done = frame_done_q;
  assign out_rd_ok  = out_rd_en && !out_empty;
  assign pop        = !in_empty && (used_q < CREDITS);
  assign eff_mode   = (issue_q == '0) ? mode : mode_q;

  assign px_r = in_dout[3*CH_W-1:2*CH_W];
  assign px_g = in_dout[2*CH_W-1:CH_W];
  assign px_b = in_dout[CH_W-1:0];

  assign avg_sum  = SW'(px_r) + SW'(px_g) + SW'(px_b);
  assign luma_sum = SW'(px_r) * SW'(77) + SW'(px_g) * SW'(150) + SW'(px_b) * SW'(29);

  assign avg_y  = CH_W'(({19'b0, s1_sum_q} * {{SW{1'b0}}, DIV3_K}) >> DIV3_SH);
  assign s2_y_d = s1_mode_q ? CH_W'(s1_sum_q >> 8) : avg_y;

  always_comb begin
    used_d = used_q;
    if (pop && !out_rd_ok) begin
      used_d = used_q + (AW+1)'(1);
    end else if (!pop && out_rd_ok) begin
      used_d = used_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_v_q       <= 1'b0;
      s1_mode_q    <= 1'b0;
      s1_sum_q     <= '0;
      s2_v_q       <= 1'b0;
      s2_y_q       <= '0;
      used_q       <= '0;
      issue_q      <= '0;
      frame_q      <= '0;
      mode_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      used_q <= used_d;
      s1_v_q <= pop;
      if (pop) begin
        s1_sum_q  <= eff_mode ? luma_sum : avg_sum;
        s1_mode_q <= eff_mode;
        mode_q    <= eff_mode;
        issue_q   <= (issue_q == LAST_PIX) ? '0 : issue_q + CW'(1);
      end
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_y_q <= s2_y_d;
      end
      frame_done_q <= s2_v_q && (frame_q == LAST_PIX);
      if (s2_v_q) begin
        frame_q <= (frame_q == LAST_PIX) ? '0 : frame_q + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_grayscale_stream.sv
// Bench for grayscale_stream: directed literal checks plus randomized traffic
// compared every cycle against a queue-based behavioural model.

module tb_grayscale_stream;
  localparam int unsigned CH_W   = 8;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned WIDTH  = 4;
  localparam int unsigned HEIGHT = 2;
  localparam int unsigned NPIX   = WIDTH * HEIGHT;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_full;
  logic        in_wr_en = 1'b0;
  logic [23:0] in_din = '0;
  logic        mode = 1'b0;
  logic        out_empty;
  logic        out_rd_en = 1'b0;
  logic [7:0]  out_dout;
  logic        frame_done;

  grayscale_stream #(
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT),
    .CH_W       (CH_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_full    (in_full),
    .in_wr_en   (in_wr_en),
    .in_din     (in_din),
    .mode       (mode),
    .out_empty  (out_empty),
    .out_rd_en  (out_rd_en),
    .out_dout   (out_dout),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned y;
    int unsigned pos;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned fpos = 0;
  logic        frame_mode = 1'b0;
  int          total = 0;
  int          bad = 0;
  int unsigned fd_cnt = 0;
  int unsigned accepted = 0;
  bit          fd_chk = 1'b0;

  function automatic int unsigned gray(int unsigned r, int unsigned g, int unsigned b, logic m);
    if (m) return (77 * r + 150 * g + 29 * b) / 256;
    return (r + g + b) / 3;
  endfunction

  task automatic check(string name, longint act, longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // One clock: compare on the falling edge, then return just after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clock);
    if (!reset) begin
      exp_q.delete();
      fpos = 0;
    end else begin
      if (!out_empty) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", out_empty, 1);
        end else begin
          check("out_dout", out_dout, exp_q[0].y);
          if (fd_chk && frame_done) check("fd_align", exp_q[0].pos, NPIX - 1);
          if (out_rd_en) void'(exp_q.pop_front());
        end
      end else if (fd_chk && frame_done) begin
        check("fd_visible", out_empty, 0);
      end
      if (frame_done) fd_cnt++;
      if (in_wr_en && !in_full) begin
        if (fpos == 0) frame_mode = mode;
        e.y   = gray(in_din[23:16], in_din[15:8], in_din[7:0], frame_mode);
        e.pos = fpos;
        exp_q.push_back(e);
        fpos = (fpos + 1) % NPIX;
        accepted++;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    in_wr_en  = 1'b0;
    out_rd_en = 1'b0;
    reset     = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic drain(string name, int budget);
    int n;
    n = 0;
    in_wr_en  = 1'b0;
    out_rd_en = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (4) tick();
    out_rd_en = 1'b0;
  endtask

  task automatic expect_head(string name, int unsigned val);
    check({name, "_vis"}, out_empty, 0);
    check(name, out_dout, val);
    out_rd_en = 1'b1;
    tick();
    out_rd_en = 1'b0;
  endtask

  initial begin
    int unsigned base;
    int unsigned fd_base;
    int          n;

    #1;
    check("rst_in_full", in_full, 0);
    check("rst_out_empty", out_empty, 1);
    check("rst_frame_done", frame_done, 0);
    check("rst_out_dout", out_dout, 0);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // Average mode with first-sample latency
    mode = 1'b0;
    in_wr_en = 1'b1; in_din = {8'd10, 8'd20, 8'd31};
    tick();
    in_din = {8'd255, 8'd255, 8'd255};
    tick();
    in_wr_en = 1'b0;
    tick();
    check("lat_early_empty", out_empty, 1);
    tick();
    expect_head("avg_10_20_31", 20);
    expect_head("avg_255", 255);
    drain("avg_drain", 50);

    // Luma mode literals
    do_reset();
    mode = 1'b1;
    in_wr_en = 1'b1;
    in_din = {8'd255, 8'd0, 8'd0};     tick();
    in_din = {8'd0, 8'd255, 8'd0};     tick();
    in_din = {8'd255, 8'd255, 8'd255}; tick();
    in_wr_en = 1'b0;
    repeat (4) tick();
    expect_head("luma_red", 76);
    expect_head("luma_green", 149);
    expect_head("luma_white", 255);
    drain("luma_drain", 50);

    // Mode toggled at pixel 3 applies from pixel 8; frame_done on pixels 7 and 15
    do_reset();
    mode = 1'b1;
    fd_base = fd_cnt;
    fd_chk = 1'b1;
    out_rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_wr_en = 1'b1; in_din = 24'($urandom);
      tick();
      in_wr_en = 1'b0;
      repeat (5) tick();
    end
    mode = 1'b0;
    for (int i = 3; i < 16; i++) begin
      in_wr_en = 1'b1; in_din = (i == 8) ? {8'd10, 8'd20, 8'd31} : 24'($urandom);
      tick();
    end
    drain("frame_drain", 100);
    fd_chk = 1'b0;
    check("frame_done_count", fd_cnt - fd_base, 2);

    // Backpressure: out FIFO held, writes attempted even while full
    do_reset();
    base = accepted;
    in_wr_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      in_din = 24'($urandom);
      tick();
    end
    check("bp_accepted", accepted - base, 2 * DEPTH);
    check("bp_in_full", in_full, 1);
    check("bp_out_nonempty", out_empty, 0);
    out_rd_en = 1'b1;
    n = 0;
    while ((accepted - base < 80 || exp_q.size() != 0) && n < 1000) begin
      in_wr_en = (accepted - base < 80);
      in_din = 24'($urandom);
      tick();
      n++;
    end
    check("bp_total", accepted - base, 80);
    drain("bp_drain", 100);

    // Asynchronous reset mid-stream with both FIFOs full
    in_wr_en = 1'b1;
    out_rd_en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      in_din = 24'($urandom);
      tick();
    end
    in_wr_en = 1'b0;
    check("pre_rst_full", in_full, 1);
    #2 reset = 1'b0;
    #1;
    check("async_in_full", in_full, 0);
    check("async_out_empty", out_empty, 1);
    check("async_frame_done", frame_done, 0);
    check("async_out_dout", out_dout, 0);
    repeat (2) tick();
    reset = 1'b1;
    out_rd_en = 1'b1;
    repeat (10) tick();
    check("post_rst_empty", out_empty, 1);
    out_rd_en = 1'b0;

    // Random stress, one phase per mode
    for (int m = 0; m < 2; m++) begin
      mode = m[0];
      base = accepted;
      fd_base = fd_cnt;
      n = 0;
      while (accepted - base < 5000 && n < 40000) begin
        in_wr_en  = ($urandom_range(0, 9) < 7);
        in_din    = 24'($urandom);
        out_rd_en = ($urandom_range(0, 9) < 6);
        tick();
        n++;
      end
      check("stress_accepted", accepted - base, 5000);
      drain("stress_drain", 2000);
      check("stress_frames", fd_cnt - fd_base, 5000 / NPIX);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
